// File: rtl/snake_pkg.sv
// Shared snake-game types: heading encoding and helpers.
// Used by direction_queue, the game-step logic and the renderer.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  // Flipping bit 1 maps up<->down and right<->left.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// dir_fifo: DEPTH x 2-bit synchronous FIFO of headings.
// Ports:
//   clk_i, rst_n_i  clock, async active-low reset
//   clear_i         sync flush (overrides push/pop)
//   push_i, data_i  write request and entry; ignored when full unless popping
//   pop_i           read request; ignored when empty
//   head_o          oldest entry (valid when count_o > 0)
//   tail_o          newest entry (valid when count_o > 0)
//   count_o         number of stored entries, 0..DEPTH
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  dir_t                       data_i,
  input  logic                       pop_i,
  output dir_t                       head_o,
  output dir_t                       tail_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dir_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff;
  logic             push_eff;

  // A pop on a full FIFO frees the slot that a same-cycle push then uses.
  always_comb begin
    pop_eff  = pop_i && (count_q != '0);
    push_eff = push_i && ((count_q != CNT_W'(DEPTH)) || pop_eff);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop_eff) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (push_eff && !pop_eff) count_d = count_q + CNT_W'(1);
    else if (pop_eff && !push_eff) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q covers them.
  always_ff @(posedge clk_i) begin
    if (push_eff && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign tail_o  = mem_q[wr_ptr_q - PTR_W'(1)];
  assign count_o = count_q;

endmodule

// File: rtl/direction_queue.sv
// direction_queue: turns debounced direction-button pulses into the snake
// heading, applied one queued press per game step.
// Ports:
//   clk_i, rst_n_i    clock, async active-low reset
//   clear_i           sync game restart (same effect as reset)
//   btn_*_i           one-cycle press pulses; priority up > right > down > left
//   tick_i            game-step strobe; pops one queued heading
//   direction_o       current heading (registered)
//   pending_o         queued presses, 0..DEPTH
//   dropped_o         one-cycle pulse: accepted press lost to a full queue
module direction_queue
  import snake_pkg::*;
#(
  parameter int   DEPTH     = 4,
  parameter dir_t RESET_DIR = DIR_RIGHT
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_i,
  input  logic                    btn_up_i,
  input  logic                    btn_right_i,
  input  logic                    btn_down_i,
  input  logic                    btn_left_i,
  input  logic                    tick_i,
  output dir_t                    direction_o,
  output logic [$clog2(DEPTH):0]  pending_o,
  output logic                    dropped_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  dir_t             direction_q, direction_d;
  logic             dropped_q, dropped_d;
  logic [CNT_W-1:0] count;
  dir_t             head, tail;
  dir_t             btn_dir;
  logic             btn_any;
  dir_t             ref_dir;
  logic             accept;
  logic             pop;
  logic             full;

  always_comb begin
    btn_any = btn_up_i | btn_right_i | btn_down_i | btn_left_i;
    if (btn_up_i)         btn_dir = DIR_UP;
    else if (btn_right_i) btn_dir = DIR_RIGHT;
    else if (btn_down_i)  btn_dir = DIR_DOWN;
    else                  btn_dir = DIR_LEFT;

    // Presses are filtered against the heading the snake will have once
    // everything already queued has been applied.
    ref_dir = (count != '0) ? tail : direction_q;
    accept  = btn_any && (btn_dir != ref_dir) && (btn_dir != opposite(ref_dir));

    pop         = tick_i && (count != '0);
    full        = (count == CNT_W'(DEPTH));
    dropped_d   = accept && full && !pop;
    direction_d = pop ? head : direction_q;
  end

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (clear_i),
    .push_i  (accept),
    .data_i  (btn_dir),
    .pop_i   (tick_i),
    .head_o  (head),
    .tail_o  (tail),
    .count_o (count)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      direction_q <= RESET_DIR;
      dropped_q   <= 1'b0;
    end else if (clear_i) begin
      direction_q <= RESET_DIR;
      dropped_q   <= 1'b0;
    end else begin
      direction_q <= direction_d;
      dropped_q   <= dropped_d;
    end
  end

  assign direction_o = direction_q;
  assign pending_o   = count;
  assign dropped_o   = dropped_q;

endmodule

// File: tb/tb_direction_queue.sv
// Self-checking bench for direction_queue: directed scenarios plus a random
// run, all compared against a queue-based model of the heading rules.
module tb_direction_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       b_up = 1'b0, b_rt = 1'b0, b_dn = 1'b0, b_lt = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir_o;
  logic [2:0] pend_o;
  logic       drop_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [1:0] mq[$];
  logic [1:0] m_dir;
  logic       m_drop;

  always #5 clk = ~clk;

  direction_queue #(.DEPTH(DEPTH), .RESET_DIR(2'd1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .clear_i     (clear),
    .btn_up_i    (b_up),
    .btn_right_i (b_rt),
    .btn_down_i  (b_dn),
    .btn_left_i  (b_lt),
    .tick_i      (tick),
    .direction_o (dir_o),
    .pending_o   (pend_o),
    .dropped_o   (drop_o)
  );

  task automatic model_reset();
    mq.delete();
    m_dir  = 2'd1;
    m_drop = 1'b0;
  endtask

  // Model of one clock edge using pre-edge inputs and state.
  task automatic model_edge(input logic u, r, dn, l, t, c);
    logic [1:0] d, rf, hd;
    logic       any, acc, popped, was_full;
    if (c) begin
      model_reset();
      return;
    end
    any = u | r | dn | l;
    d = u ? 2'd0 : r ? 2'd1 : dn ? 2'd2 : 2'd3;
    rf = (mq.size() > 0) ? mq[$] : m_dir;
    acc = any && (d != rf) && (d != (rf ^ 2'b10));
    was_full = (mq.size() == DEPTH);
    popped = t && (mq.size() > 0);
    m_drop = 1'b0;
    if (popped) begin
      hd = mq.pop_front();
      m_dir = hd;
    end
    if (acc) begin
      if (was_full && !popped) m_drop = 1'b1;
      else mq.push_back(d);
    end
  endtask

  // Drive one cycle of pulses, let the edge happen, then release them.
  task automatic cyc(input logic u, r, dn, l, t, c);
    @(negedge clk);
    b_up = u; b_rt = r; b_dn = dn; b_lt = l; tick = t; clear = c;
    @(posedge clk);
    model_edge(u, r, dn, l, t, c);
    #1;
    b_up = 0; b_rt = 0; b_dn = 0; b_lt = 0; tick = 0; clear = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      n_checks++;
      if (dir_o !== 2'd1 || pend_o !== 3'd0 || drop_o !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_idle[%0d]: got dir=%0d pend=%0d drop=%0d, want dir=1 pend=0 drop=0",
                 i, dir_o, pend_o, drop_o);
      end
    end
  endtask

  task automatic test_turns();
    logic [4:0] stim [4] = '{5'b10000, 5'b00010, 5'b00001, 5'b00001};
    logic [1:0] exp_dir [4] = '{2'd1, 2'd1, 2'd0, 2'd3};
    logic [2:0] exp_pend [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(stim[i][4], stim[i][3], stim[i][2], stim[i][1], stim[i][0], 0);
      n_checks++;
      if (dir_o !== exp_dir[i] || pend_o !== exp_pend[i]) begin
        n_errors++;
        $display("FAIL turns[%0d]: got dir=%0d pend=%0d, want dir=%0d pend=%0d",
                 i, dir_o, pend_o, exp_dir[i], exp_pend[i]);
      end
    end
  endtask

  task automatic test_reject();
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    n_checks++;
    if (pend_o !== 3'd0) begin
      n_errors++;
      $display("FAIL reject_reverse: got pend=%0d want 0", pend_o);
    end
    cyc(0, 1, 0, 0, 0, 0);
    n_checks++;
    if (pend_o !== 3'd0 || dir_o !== 2'd1) begin
      n_errors++;
      $display("FAIL reject_same: got pend=%0d dir=%0d want pend=0 dir=1", pend_o, dir_o);
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    n_checks++;
    if (pend_o !== 3'd4 || drop_o !== 1'b0) begin
      n_errors++;
      $display("FAIL fill: got pend=%0d drop=%0d want pend=4 drop=0", pend_o, drop_o);
    end
    cyc(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (pend_o !== 3'd4 || drop_o !== 1'b1) begin
      n_errors++;
      $display("FAIL drop_pulse: got pend=%0d drop=%0d want pend=4 drop=1", pend_o, drop_o);
    end
    cyc(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (drop_o !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_clear: got drop=%0d want 0", drop_o);
    end
    cyc(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (pend_o !== 3'd4 || drop_o !== 1'b0 || dir_o !== 2'd0) begin
      n_errors++;
      $display("FAIL full_push_pop: got pend=%0d drop=%0d dir=%0d want pend=4 drop=0 dir=0",
               pend_o, drop_o, dir_o);
    end
    // Drain: order must be left, down, right, up.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      n_checks++;
      if (dir_o !== m_dir || pend_o !== 3'(mq.size())) begin
        n_errors++;
        $display("FAIL drain[%0d]: got dir=%0d pend=%0d want dir=%0d pend=%0d",
                 i, dir_o, pend_o, m_dir, mq.size());
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(1, 0, 0, 1, 0, 0);
    n_checks++;
    if (pend_o !== 3'd1) begin
      n_errors++;
      $display("FAIL priority_pend: got pend=%0d want 1", pend_o);
    end
    cyc(0, 0, 0, 0, 1, 0);
    n_checks++;
    if (dir_o !== 2'd0 || pend_o !== 3'd0) begin
      n_errors++;
      $display("FAIL priority_head: got dir=%0d pend=%0d want dir=0 pend=0", dir_o, pend_o);
    end
    // No bypass: press with tick on empty queue applies only at the next tick.
    cyc(0, 1, 0, 0, 1, 0);
    n_checks++;
    if (dir_o !== 2'd0 || pend_o !== 3'd1) begin
      n_errors++;
      $display("FAIL no_bypass: got dir=%0d pend=%0d want dir=0 pend=1", dir_o, pend_o);
    end
  endtask

  task automatic test_clear_reset();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    n_checks++;
    if (pend_o !== 3'd3) begin
      n_errors++;
      $display("FAIL preclear_pend: got pend=%0d want 3", pend_o);
    end
    cyc(0, 0, 1, 0, 1, 1);
    n_checks++;
    if (pend_o !== 3'd0 || dir_o !== 2'd1 || drop_o !== 1'b0) begin
      n_errors++;
      $display("FAIL clear: got pend=%0d dir=%0d drop=%0d want pend=0 dir=1 drop=0",
               pend_o, dir_o, drop_o);
    end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pend_o !== 3'd0 || dir_o !== 2'd1 || drop_o !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got pend=%0d dir=%0d drop=%0d want pend=0 dir=1 drop=0",
               pend_o, dir_o, drop_o);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic u, r, dn, l, t, c;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      u  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 3) == 0);
      dn = ($urandom_range(0, 3) == 0);
      l  = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 80) == 0);
      cyc(u, r, dn, l, t, c);
      n_checks++;
      if (dir_o !== m_dir || pend_o !== 3'(mq.size()) || drop_o !== m_drop) begin
        n_errors++;
        $display("FAIL random[%0d]: got dir=%0d pend=%0d drop=%0d want dir=%0d pend=%0d drop=%0d",
                 i, dir_o, pend_o, drop_o, m_dir, mq.size(), m_drop);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_turns();
    test_reject();
    test_full_drop();
    test_priority();
    test_clear_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
